// File: rtl/bb_core_seq_pkg.sv
// Shared types for the BitBlade tile sequencer: FSM states, precision codes
// and the packed precision word handed to the core.
package bb_core_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FLUSH = 3'd3,
        ST_WAIT  = 3'd4,
        ST_PSUM  = 3'd5
    } seq_state_e;

    localparam logic [1:0] PREC_2B = 2'd0;
    localparam logic [1:0] PREC_4B = 2'd1;
    localparam logic [1:0] PREC_8B = 2'd2;

    // Field order matches the core's {act_prec, wgt_prec} input.
    typedef struct packed {
        logic [1:0] act;
        logic [1:0] wgt;
    } prec_t;

endpackage

// File: rtl/bb_core_seq_vld_pipe.sv
// Delays each operand read strobe (and its first-step tag) by the buffer read
// latency so core_vld / sel_bias line up with the data at the core input.
module bb_vld_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic rd_en,
    input  logic first,
    output logic core_vld,
    output logic sel_bias
);

    logic [RD_LAT-1:0] vld_pipe;
    logic [RD_LAT-1:0] first_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe   <= '0;
            first_pipe <= '0;
        end else begin
            vld_pipe[0]   <= rd_en;
            first_pipe[0] <= rd_en & first;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]   <= vld_pipe[i-1];
                first_pipe[i] <= first_pipe[i-1];
            end
        end
    end

    assign core_vld = vld_pipe[RD_LAT-1];
    assign sel_bias = first_pipe[RD_LAT-1];

endmodule

// File: rtl/bb_core_seq.sv
// Tile sequencer: per tile issues Num_Step operand reads, drains the read
// pipe, flushes the core, waits for done and hands the psum downstream.
module bb_core_seq
    import bb_core_seq_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int STEP_W       = 12,
    parameter int TILE_W       = 8,
    parameter int RD_LAT       = 1,
    parameter int DONE_TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_Start,
    input  logic [1:0]        i_Act_Prec,
    input  logic [1:0]        i_Wgt_Prec,
    input  logic [STEP_W-1:0] i_Num_Step,
    input  logic [TILE_W-1:0] i_Num_Tile,
    input  logic [ADDR_W-1:0] i_Base_Addr,
    input  logic              i_Stall,
    input  logic              i_Core_Done,
    input  logic              i_Psum_Rdy,
    output logic              o_Busy,
    output logic              o_Rd_En,
    output logic [ADDR_W-1:0] o_Rd_Addr,
    output logic [3:0]        o_Precision,
    output logic              o_Core_Vld,
    output logic              o_Sel_Bias,
    output logic              o_Flush,
    output logic              o_Psum_Vld,
    output logic              o_Job_Done,
    output logic              o_Err
);

    // One counter serves both the drain delay and the done timeout.
    localparam int CNT_MAX = (DONE_TIMEOUT > RD_LAT) ? DONE_TIMEOUT : RD_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    seq_state_e        state;
    logic [STEP_W-1:0] num_step;
    logic [STEP_W-1:0] step;
    logic [TILE_W-1:0] num_tile;
    logic [TILE_W-1:0] tile;
    logic [ADDR_W-1:0] rd_addr;
    logic [CNT_W-1:0]  cnt;
    prec_t             prec;
    logic              err;
    logic              job_done;
    logic              rd_en;
    logic              first;

    // Stall gates the read in the same cycle, so the strobe is decoded, not registered.
    assign rd_en = (state == ST_ISSUE) && !i_Stall;
    assign first = (step == '0);

    bb_vld_pipe #(
        .RD_LAT(RD_LAT)
    ) u_vld_pipe (
        .clk     (CLK),
        .rst     (RST),
        .rd_en   (rd_en),
        .first   (first),
        .core_vld(o_Core_Vld),
        .sel_bias(o_Sel_Bias)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            num_step <= '0;
            step     <= '0;
            num_tile <= '0;
            tile     <= '0;
            rd_addr  <= '0;
            cnt      <= '0;
            prec     <= '0;
            err      <= 1'b0;
            job_done <= 1'b0;
        end else begin
            job_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_Start) begin
                        if (i_Num_Step == '0 || i_Num_Tile == '0) begin
                            err <= 1'b1;
                        end else begin
                            num_step <= i_Num_Step;
                            num_tile <= i_Num_Tile;
                            prec     <= '{act: i_Act_Prec, wgt: i_Wgt_Prec};
                            rd_addr  <= i_Base_Addr;
                            step     <= '0;
                            tile     <= '0;
                            err      <= 1'b0;
                            state    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!i_Stall) begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                        step    <= step + STEP_W'(1);
                        if (step == num_step - STEP_W'(1)) begin
                            cnt   <= '0;
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cnt == CNT_W'(RD_LAT - 1)) state <= ST_FLUSH;
                    else                           cnt   <= cnt + CNT_W'(1);
                end
                ST_FLUSH: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Done is still honoured on the DONE_TIMEOUT-th cycle after the flush.
                    if (i_Core_Done) begin
                        state <= ST_PSUM;
                    end else if (cnt == CNT_W'(DONE_TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_PSUM: begin
                    if (i_Psum_Rdy) begin
                        tile <= tile + TILE_W'(1);
                        step <= '0;
                        if (tile == num_tile - TILE_W'(1)) begin
                            job_done <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_Busy      = (state != ST_IDLE);
    assign o_Rd_En     = rd_en;
    assign o_Rd_Addr   = rd_addr;
    assign o_Precision = prec;
    assign o_Flush     = (state == ST_FLUSH);
    assign o_Psum_Vld  = (state == ST_PSUM);
    assign o_Job_Done  = job_done;
    assign o_Err       = err;

endmodule

// File: tb/tb_bb_core_seq.sv
// Self-checking bench for bb_core_seq: directed scenarios plus random jobs,
// checked against a job-level model of addresses, strobes and pulse counts.
module tb_bb_core_seq;

    localparam int ADDR_W = 10;
    localparam int STEP_W = 12;
    localparam int TILE_W = 8;
    localparam int RD_LAT = 1;
    localparam int TMO    = 64;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              i_Start = 1'b0;
    logic [1:0]        i_Act_Prec = '0;
    logic [1:0]        i_Wgt_Prec = '0;
    logic [STEP_W-1:0] i_Num_Step = '0;
    logic [TILE_W-1:0] i_Num_Tile = '0;
    logic [ADDR_W-1:0] i_Base_Addr = '0;
    logic              i_Stall = 1'b0;
    logic              i_Core_Done = 1'b0;
    logic              i_Psum_Rdy = 1'b0;
    logic              o_Busy, o_Rd_En, o_Core_Vld, o_Sel_Bias, o_Flush;
    logic              o_Psum_Vld, o_Job_Done, o_Err;
    logic [ADDR_W-1:0] o_Rd_Addr;
    logic [3:0]        o_Precision;

    bb_core_seq #(
        .ADDR_W(ADDR_W), .STEP_W(STEP_W), .TILE_W(TILE_W),
        .RD_LAT(RD_LAT), .DONE_TIMEOUT(TMO)
    ) dut (
        .CLK(CLK), .RST(RST), .i_Start(i_Start), .i_Act_Prec(i_Act_Prec),
        .i_Wgt_Prec(i_Wgt_Prec), .i_Num_Step(i_Num_Step), .i_Num_Tile(i_Num_Tile),
        .i_Base_Addr(i_Base_Addr), .i_Stall(i_Stall), .i_Core_Done(i_Core_Done),
        .i_Psum_Rdy(i_Psum_Rdy), .o_Busy(o_Busy), .o_Rd_En(o_Rd_En),
        .o_Rd_Addr(o_Rd_Addr), .o_Precision(o_Precision), .o_Core_Vld(o_Core_Vld),
        .o_Sel_Bias(o_Sel_Bias), .o_Flush(o_Flush), .o_Psum_Vld(o_Psum_Vld),
        .o_Job_Done(o_Job_Done), .o_Err(o_Err)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    // Mid-cycle monitor of everything the job model predicts.
    logic [ADDR_W-1:0] rd_q[$];
    bit                sel_q[$];
    int n_flush, n_psum, n_jd, n_ovl, n_orphan, n_prec_bad;
    logic [3:0] exp_prec;

    always @(negedge CLK) begin
        if (!RST) begin
            if (o_Rd_En) rd_q.push_back(o_Rd_Addr);
            if (o_Core_Vld) sel_q.push_back(o_Sel_Bias);
            if (o_Sel_Bias && !o_Core_Vld) n_orphan++;
            if (o_Flush) n_flush++;
            if (o_Psum_Vld) n_psum++;
            if (o_Job_Done) n_jd++;
            if ((o_Core_Vld || o_Sel_Bias) && o_Flush) n_ovl++;
            if (o_Busy && o_Precision !== exp_prec) n_prec_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_mon();
        rd_q.delete();
        sel_q.delete();
        n_flush = 0; n_psum = 0; n_jd = 0; n_ovl = 0; n_orphan = 0; n_prec_bad = 0;
    endtask

    task automatic start_job(input int ns, input int nt, input int base,
                             input logic [1:0] ap, input logic [1:0] wp);
        i_Start     = 1'b1;
        i_Num_Step  = STEP_W'(ns);
        i_Num_Tile  = TILE_W'(nt);
        i_Base_Addr = ADDR_W'(base);
        i_Act_Prec  = ap;
        i_Wgt_Prec  = wp;
        exp_prec    = {ap, wp};
        step();
        i_Start = 1'b0;
    endtask

    // Plays buffer, core and output buffer until the job-done pulse shows up.
    task automatic drive_to_done(input int stall_pct, input int rdy_wait,
                                 input int done_wait, input bit inj);
        int fl_age = -1;
        int pcnt = 0;
        bit seen = 0;
        for (int c = 0; c < 2000; c++) begin
            i_Stall = ($urandom_range(99) < stall_pct);
            if (o_Flush) fl_age = 0;
            else if (fl_age >= 0) fl_age++;
            i_Core_Done = (fl_age == done_wait + 1);
            if (i_Core_Done) fl_age = -1;
            i_Psum_Rdy = 1'b0;
            if (o_Psum_Vld) begin
                if (pcnt == rdy_wait) begin i_Psum_Rdy = 1'b1; pcnt = 0; end
                else pcnt++;
            end
            i_Start = inj && (c == 2);
            if (i_Start) begin
                i_Num_Step  = STEP_W'($urandom_range(30, 5));
                i_Num_Tile  = TILE_W'($urandom_range(9, 5));
                i_Base_Addr = ADDR_W'($urandom);
                i_Act_Prec  = ~exp_prec[3:2];
                i_Wgt_Prec  = ~exp_prec[1:0];
            end
            step();
            if (o_Job_Done) begin seen = 1; break; end
        end
        i_Stall = 0; i_Core_Done = 0; i_Psum_Rdy = 0; i_Start = 0;
        chk("job_done_seen", 32'(seen), 32'd1);
    endtask

    // Job model: tile t, step s reads base + t*ns + s (mod 2**ADDR_W); bias on each tile's first.
    task automatic verify(input string tag, input int ns, input int nt, input int base,
                          input int rdy_wait);
        int bad;
        step();
        chk({tag, "_jd_single"}, 32'(o_Job_Done), 32'd0);
        chk({tag, "_rd_count"}, 32'(rd_q.size()), 32'(ns * nt));
        if (rd_q.size() == ns * nt) begin
            bad = 0;
            for (int t = 0; t < nt; t++)
                for (int s = 0; s < ns; s++)
                    if (rd_q[t*ns+s] !== ADDR_W'((base + t*ns + s) % (1 << ADDR_W))) bad++;
            chk({tag, "_addr_seq_bad"}, 32'(bad), 32'd0);
        end
        chk({tag, "_vld_count"}, 32'(sel_q.size()), 32'(ns * nt));
        bad = 0;
        for (int i = 0; i < sel_q.size(); i++)
            if (sel_q[i] != ((i % ns) == 0)) bad++;
        chk({tag, "_sel_pattern_bad"}, 32'(bad), 32'd0);
        chk({tag, "_flush_count"}, 32'(n_flush), 32'(nt));
        chk({tag, "_psum_cycles"}, 32'(n_psum), 32'(nt * (rdy_wait + 1)));
        chk({tag, "_jd_count"}, 32'(n_jd), 32'd1);
        chk({tag, "_overlap"}, 32'(n_ovl + n_orphan), 32'd0);
        chk({tag, "_prec_stable_bad"}, 32'(n_prec_bad), 32'd0);
        chk({tag, "_idle_state"}, {o_Busy, o_Err, o_Precision}, {1'b0, 1'b0, exp_prec});
    endtask

    initial begin
        int ns, nt, base, rw, dw, fl_found, rst_flush;
        exp_prec = '0;
        clear_mon();

        // Reset state
        step(); step();
        chk("reset_outputs", {o_Busy, o_Rd_En, o_Rd_Addr, o_Precision, o_Core_Vld, o_Sel_Bias,
                              o_Flush, o_Psum_Vld, o_Job_Done, o_Err}, 32'd0);
        RST = 1'b0;
        step();

        // T1: wrap-around addresses and exact cycle timing
        clear_mon();
        start_job(4, 1, 'h3FE, 2'd2, 2'd1);
        chk("t1_c1", {o_Rd_En, o_Rd_Addr, o_Core_Vld}, {1'b1, 10'h3FE, 1'b0});
        step();
        chk("t1_c2", {o_Rd_En, o_Rd_Addr, o_Core_Vld, o_Sel_Bias}, {1'b1, 10'h3FF, 1'b1, 1'b1});
        step();
        chk("t1_c3", {o_Rd_En, o_Rd_Addr, o_Core_Vld, o_Sel_Bias}, {1'b1, 10'h000, 1'b1, 1'b0});
        step();
        chk("t1_c4", {o_Rd_En, o_Rd_Addr, o_Core_Vld, o_Sel_Bias}, {1'b1, 10'h001, 1'b1, 1'b0});
        step();
        chk("t1_c5", {o_Rd_En, o_Core_Vld, o_Flush, o_Busy}, {1'b0, 1'b1, 1'b0, 1'b1});
        step();
        chk("t1_c6_flush", {o_Core_Vld, o_Flush}, {1'b0, 1'b1});
        step();
        chk("t1_c7_wait", {o_Flush, o_Busy, o_Psum_Vld}, {1'b0, 1'b1, 1'b0});
        i_Core_Done = 1'b1;
        step();
        i_Core_Done = 1'b0;
        chk("t1_c8_psum", o_Psum_Vld, 1'b1);
        i_Psum_Rdy = 1'b1;
        step();
        i_Psum_Rdy = 1'b0;
        chk("t1_c9_jd", {o_Job_Done, o_Busy, o_Psum_Vld}, {1'b1, 1'b0, 1'b0});
        verify("t1", 4, 1, 'h3FE, 0);

        // T2: stall on the second issue cycle
        clear_mon();
        start_job(4, 1, 'h010, 2'd0, 2'd2);
        chk("t2_c1", {o_Rd_En, o_Rd_Addr}, {1'b1, 10'h010});
        step();
        i_Stall = 1'b1;
        #1;
        chk("t2_c2_stall", {o_Rd_En, o_Rd_Addr, o_Core_Vld}, {1'b0, 10'h011, 1'b1});
        step();
        i_Stall = 1'b0;
        #1;
        chk("t2_c3_gap", {o_Rd_En, o_Rd_Addr, o_Core_Vld}, {1'b1, 10'h011, 1'b0});
        step(); step();
        chk("t2_c5", {o_Rd_En, o_Rd_Addr, o_Core_Vld}, {1'b1, 10'h013, 1'b1});
        drive_to_done(0, 0, 1, 0);
        verify("t2", 4, 1, 'h010, 0);

        // T3: three tiles with slow psum acceptance
        clear_mon();
        start_job(2, 3, 'h100, 2'd1, 2'd1);
        drive_to_done(0, 3, 2, 0);
        verify("t3", 2, 3, 'h100, 3);

        // T4: core done never arrives
        clear_mon();
        start_job(1, 1, 'h020, 2'd2, 2'd2);
        fl_found = 0;
        for (int c = 0; c < 20; c++) begin
            if (o_Flush) begin fl_found = 1; break; end
            step();
        end
        chk("t4_flush_found", 32'(fl_found), 32'd1);
        repeat (TMO - 1) step();
        chk("t4_before_timeout", {o_Busy, o_Err}, {1'b1, 1'b0});
        step(); step();
        chk("t4_after_timeout", {o_Busy, o_Err}, {1'b0, 1'b1});
        clear_mon();
        start_job(3, 2, 'h3FF, 2'd0, 2'd0);
        chk("t4_err_cleared", {o_Busy, o_Err}, {1'b1, 1'b0});
        drive_to_done(20, 1, 0, 0);
        verify("t4b", 3, 2, 'h3FF, 1);

        // T5: illegal configs, then start while busy is ignored
        clear_mon();
        start_job(0, 2, 'h050, 2'd1, 2'd2);
        chk("t5_zero_step", {o_Busy, o_Err, o_Rd_En}, {1'b0, 1'b1, 1'b0});
        start_job(3, 0, 'h050, 2'd1, 2'd2);
        step(); step();
        chk("t5_zero_tile", {o_Busy, o_Err, 32'(rd_q.size())}, {1'b0, 1'b1, 32'd0});
        clear_mon();
        start_job(3, 1, 'h040, 2'd1, 2'd0);
        drive_to_done(0, 0, 0, 1);
        verify("t5_busy_start", 3, 1, 'h040, 0);

        // T6: reset mid-issue, then a clean job
        clear_mon();
        start_job(8, 2, 'h055, 2'd2, 2'd0);
        step(); step();
        RST = 1'b1;
        step();
        chk("t6_reset_outputs", {o_Busy, o_Rd_En, o_Rd_Addr, o_Precision, o_Core_Vld,
                                 o_Sel_Bias, o_Flush, o_Psum_Vld, o_Job_Done, o_Err}, 32'd0);
        rst_flush = 0;
        for (int c = 0; c < 3; c++) begin
            if (o_Flush) rst_flush++;
            step();
        end
        RST = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (o_Flush || o_Busy) rst_flush++;
            step();
        end
        chk("t6_no_flush", 32'(rst_flush), 32'd0);
        clear_mon();
        start_job(5, 2, 'h1F0, 2'd1, 2'd2);
        drive_to_done(0, 0, 3, 0);
        verify("t6_fresh", 5, 2, 'h1F0, 0);

        // Random jobs
        for (int j = 0; j < 8; j++) begin
            ns   = $urandom_range(20, 1);
            nt   = $urandom_range(4, 1);
            base = $urandom_range(1023);
            rw   = $urandom_range(3);
            dw   = $urandom_range(10);
            clear_mon();
            start_job(ns, nt, base, 2'($urandom_range(2)), 2'($urandom_range(2)));
            drive_to_done(30, rw, dw, j[0]);
            verify($sformatf("rnd%0d", j), ns, nt, base, rw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
